// File: rtl/iq_comp_pkg.sv
// Shared definitions for the IQ compensation loop: compensator modes,
// settle-detector state encoding and lane indexing for the Wr/Wj pair.
package iq_comp_pkg;

  localparam logic [1:0] BYPASS = 2'b00;
  localparam logic [1:0] INT_W  = 2'b01;
  localparam logic [1:0] EXT_W  = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    TRACK   = 2'b01,
    SETTLED = 2'b10,
    TIMEOUT = 2'b11
  } state_t;

  // lane 0 carries Wr, lane 1 carries Wj
  localparam int NUM_LANES = 2;
  localparam int LANE_R    = 0;
  localparam int LANE_J    = 1;

endpackage

// File: rtl/iq_settle_detect_if.sv
// Bundle between the compensator/MCU side and the settle detector.
interface iq_settle_detect_if #(
  parameter int W_WIDTH = 13
);
  logic                      enable;
  logic [1:0]                op_mode;
  logic signed [W_WIDTH-1:0] Wr;
  logic signed [W_WIDTH-1:0] Wj;
  logic [7:0]                thresh;
  logic                      freeze_iqcomp;
  logic                      settled;
  logic                      timeout;
  logic [1:0]                state;
  logic signed [W_WIDTH-1:0] Wr_hold;
  logic signed [W_WIDTH-1:0] Wj_hold;

  modport master (
    output enable, op_mode, Wr, Wj, thresh,
    input  freeze_iqcomp, settled, timeout, state, Wr_hold, Wj_hold
  );

  modport slave (
    input  enable, op_mode, Wr, Wj, thresh,
    output freeze_iqcomp, settled, timeout, state, Wr_hold, Wj_hold
  );
endinterface

// File: rtl/iq_span_tracker.sv
// Running signed min/max of one weight over a window. span is combinational
// and already folds in the current sample, so at the last window sample it
// is the full window's peak-to-peak value.
module iq_span_tracker #(
  parameter int W_WIDTH = 13
) (
  input  logic                      clk,
  input  logic                      RESETn,
  input  logic                      clr,
  input  logic                      load,
  input  logic                      upd,
  input  logic signed [W_WIDTH-1:0] sample,
  output logic signed [W_WIDTH-1:0] min,
  output logic signed [W_WIDTH-1:0] max,
  output logic [W_WIDTH:0]          span
);
  logic signed [W_WIDTH-1:0] lo, hi;

  // next extremes including the present sample; span is one bit wider so
  // full-scale swings do not wrap
  always_comb begin
    lo = min;
    hi = max;
    if (load) begin
      lo = sample;
      hi = sample;
    end else begin
      if (sample < min) lo = sample;
      if (sample > max) hi = sample;
    end
    span = {hi[W_WIDTH-1], hi} - {lo[W_WIDTH-1], lo};
  end

  // extremes register; cleared whenever monitoring is not requested
  always_ff @(posedge clk) begin
    if (!RESETn || clr) begin
      min <= '0;
      max <= '0;
    end else if (load || upd) begin
      min <= lo;
      max <= hi;
    end
  end
endmodule

// File: rtl/iq_settle_detect.sv
// Convergence monitor for the IQ compensator. Measures the Wr/Wj span per
// window, counts consecutive stable windows, freezes the compensator once
// settled (or on timeout) and latches the final weights for readback.
module iq_settle_detect
  import iq_comp_pkg::*;
#(
  parameter int W_WIDTH         = 13,
  parameter int WIN_LOG2        = 4,
  parameter int HOLD_WINDOWS    = 4,
  parameter int TIMEOUT_WINDOWS = 64
) (
  input  logic clk,
  input  logic RESETn,
  iq_settle_detect_if.slave bus
);
  localparam int SC_W = $clog2(HOLD_WINDOWS + 1);
  localparam int WC_W = $clog2(TIMEOUT_WINDOWS + 1);
  localparam logic [WIN_LOG2-1:0] K_LAST  = '1;
  localparam logic [SC_W-1:0]     HOLD_N  = SC_W'(HOLD_WINDOWS);
  localparam logic [WC_W-1:0]     TO_N    = WC_W'(TIMEOUT_WINDOWS);

  state_t                                st;
  logic [WIN_LOG2-1:0]                   k;
  logic [SC_W-1:0]                       stable_cnt, stable_nx;
  logic [WC_W-1:0]                       win_cnt, win_nx;
  logic                                  freeze_r, settled_r, timeout_r;
  logic [NUM_LANES-1:0][W_WIDTH-1:0]     w_in, w_min, w_max, hold;
  logic [NUM_LANES-1:0][W_WIDTH:0]       span;
  logic [NUM_LANES-1:0]                  lane_ok;
  logic                                  go, in_track, load, win_stable;

  assign go       = bus.enable && (bus.op_mode == INT_W);
  assign in_track = (st == TRACK);
  assign load     = in_track && (k == '0);
  assign w_in[LANE_R] = bus.Wr;
  assign w_in[LANE_J] = bus.Wj;

  iq_span_tracker #(.W_WIDTH(W_WIDTH)) u_trk [NUM_LANES-1:0] (
    .clk    (clk),
    .RESETn (RESETn),
    .clr    (!go),
    .load   (load),
    .upd    (in_track),
    .sample (w_in),
    .min    (w_min),
    .max    (w_max),
    .span   (span)
  );

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign lane_ok[i] = (span[i] <= (W_WIDTH+1)'(bus.thresh));

    // once a window has started its extremes must stay ordered
    always_comb begin
      if (RESETn && in_track && (k != '0))
        assert ($signed(w_max[i]) >= $signed(w_min[i]));
    end
  end

  assign win_stable = &lane_ok;

  // window-end counter updates
  always_comb begin
    stable_nx = win_stable ? stable_cnt + SC_W'(1) : '0;
    win_nx    = win_cnt + WC_W'(1);
  end

  // control FSM with registered outputs; settle takes priority over timeout
  always_ff @(posedge clk) begin
    if (!RESETn) begin
      st         <= IDLE;
      k          <= '0;
      stable_cnt <= '0;
      win_cnt    <= '0;
      freeze_r   <= 1'b0;
      settled_r  <= 1'b0;
      timeout_r  <= 1'b0;
      hold       <= '0;
    end else if (!go) begin
      st         <= IDLE;
      k          <= '0;
      stable_cnt <= '0;
      win_cnt    <= '0;
      freeze_r   <= 1'b0;
      settled_r  <= 1'b0;
      timeout_r  <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          st         <= TRACK;
          k          <= '0;
          stable_cnt <= '0;
          win_cnt    <= '0;
        end
        TRACK: begin
          k <= k + WIN_LOG2'(1);
          if (k == K_LAST) begin
            stable_cnt <= stable_nx;
            win_cnt    <= win_nx;
            if (stable_nx == HOLD_N) begin
              st        <= SETTLED;
              freeze_r  <= 1'b1;
              settled_r <= 1'b1;
              hold      <= w_in;
            end else if (win_nx == TO_N) begin
              st        <= TIMEOUT;
              freeze_r  <= 1'b1;
              timeout_r <= 1'b1;
              hold      <= w_in;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.freeze_iqcomp = freeze_r;
  assign bus.settled       = settled_r;
  assign bus.timeout       = timeout_r;
  assign bus.state         = st;
  assign bus.Wr_hold       = hold[LANE_R];
  assign bus.Wj_hold       = hold[LANE_J];
endmodule

// File: tb/tb_iq_settle_detect.sv
module tb_iq_settle_detect;
  localparam int W    = 13;
  localparam int WLOG = 4;
  localparam int WIN  = 1 << WLOG;
  localparam int HOLD = 4;
  localparam int TO   = 64;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int checks   = 0;
  int failures = 0;

  iq_settle_detect_if #(.W_WIDTH(W)) bus ();

  iq_settle_detect #(
    .W_WIDTH(W), .WIN_LOG2(WLOG), .HOLD_WINDOWS(HOLD), .TIMEOUT_WINDOWS(TO)
  ) dut (
    .clk    (clk),
    .RESETn (rstn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  logic [1:0] m_st = 2'd0;
  int m_stable = 0, m_wins = 0, m_hr = 0, m_hj = 0;
  int q_r[$], q_j[$];

  function automatic int span_of(int q[$], int last);
    int lo = last, hi = last;
    foreach (q[i]) begin
      if (q[i] < lo) lo = q[i];
      if (q[i] > hi) hi = q[i];
    end
    return hi - lo;
  endfunction

  function automatic bit win_ok();
    return (span_of(q_r, int'(bus.Wr)) <= int'(bus.thresh)) &&
           (span_of(q_j, int'(bus.Wj)) <= int'(bus.thresh));
  endfunction

  always @(posedge clk) begin
    if (!rstn) begin
      m_st <= 2'd0; m_stable <= 0; m_wins <= 0; m_hr <= 0; m_hj <= 0;
      q_r.delete(); q_j.delete();
    end else if (!(bus.enable && bus.op_mode == 2'b01)) begin
      m_st <= 2'd0; m_stable <= 0; m_wins <= 0;
      q_r.delete(); q_j.delete();
    end else if (m_st == 2'd0) begin
      m_st <= 2'd1;
    end else if (m_st == 2'd1) begin
      if (q_r.size() == WIN - 1) begin
        if (win_ok() && (m_stable + 1 >= HOLD)) begin
          m_st <= 2'd2; m_hr <= int'(bus.Wr); m_hj <= int'(bus.Wj);
        end else if (m_wins + 1 >= TO) begin
          m_st <= 2'd3; m_hr <= int'(bus.Wr); m_hj <= int'(bus.Wj);
        end
        m_stable <= win_ok() ? m_stable + 1 : 0;
        m_wins   <= m_wins + 1;
        q_r.delete(); q_j.delete();
      end else begin
        q_r.push_back(int'(bus.Wr));
        q_j.push_back(int'(bus.Wj));
      end
    end
  end

  task automatic do_reset();
    rstn = 1'b0; bus.enable = 1'b0; bus.op_mode = 2'b00;
    bus.Wr = '0; bus.Wj = '0; bus.thresh = '0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; bus.enable = 1'b1; bus.op_mode = 2'b01;
    bus.Wr = 13'sd55; bus.Wj = -13'sd9; bus.thresh = 8'd200;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.state, bus.freeze_iqcomp, bus.settled, bus.timeout, bus.Wr_hold, bus.Wj_hold} !== '0) begin
      failures++;
      $display("FAIL reset_state got st=%0d frz=%0b set=%0b to=%0b hr=%0d hj=%0d want all 0",
               bus.state, bus.freeze_iqcomp, bus.settled, bus.timeout, bus.Wr_hold, bus.Wj_hold);
    end
    do_reset();
  endtask

  task automatic test_settle_const();
    int got = 0;
    do_reset();
    bus.Wr = 13'sd100; bus.Wj = -13'sd37; bus.thresh = 8'd0;
    bus.op_mode = 2'b01; bus.enable = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.state !== 2'b01) begin
      failures++;
      $display("FAIL track_entry got=%0d want=1", bus.state);
    end
    for (int n = 1; n <= 200 && got == 0; n++) begin
      @(negedge clk);
      if (bus.freeze_iqcomp === 1'b1) got = n;
    end
    checks++;
    if (got != 64) begin
      failures++;
      $display("FAIL settle_latency got=%0d want=64", got);
    end
    checks++;
    if ({bus.state, bus.settled, bus.timeout} !== {2'b10, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL settle_flags got st=%0d set=%0b to=%0b want st=2 set=1 to=0",
               bus.state, bus.settled, bus.timeout);
    end
    checks++;
    if ($signed(bus.Wr_hold) !== 100 || $signed(bus.Wj_hold) !== -37) begin
      failures++;
      $display("FAIL settle_hold got hr=%0d hj=%0d want 100 -37",
               $signed(bus.Wr_hold), $signed(bus.Wj_hold));
    end
  endtask

  task automatic test_timeout_osc();
    int got = 0, last = 0;
    do_reset();
    bus.Wr = '0; bus.Wj = '0; bus.thresh = 8'd2;
    bus.op_mode = 2'b01; bus.enable = 1'b1;
    @(negedge clk);
    for (int n = 1; n <= 1100 && got == 0; n++) begin
      last = (n % 2) ? 3 : 0;
      bus.Wr = W'(last);
      @(negedge clk);
      if (bus.freeze_iqcomp === 1'b1) got = n;
    end
    checks++;
    if (got != 1024) begin
      failures++;
      $display("FAIL timeout_latency got=%0d want=1024", got);
    end
    checks++;
    if ({bus.state, bus.settled, bus.timeout} !== {2'b11, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL timeout_flags got st=%0d set=%0b to=%0b want st=3 set=0 to=1",
               bus.state, bus.settled, bus.timeout);
    end
    checks++;
    if ($signed(bus.Wr_hold) !== last) begin
      failures++;
      $display("FAIL timeout_hold got=%0d want=%0d", $signed(bus.Wr_hold), last);
    end
  endtask

  task automatic test_spike();
    int got = 0;
    do_reset();
    bus.Wr = 13'sd200; bus.Wj = -13'sd50; bus.thresh = 8'd5;
    bus.op_mode = 2'b01; bus.enable = 1'b1;
    @(negedge clk);
    for (int n = 1; n <= 300 && got == 0; n++) begin
      bus.Wj = (n == 54) ? -13'sd44 : -13'sd50;
      @(negedge clk);
      if (bus.freeze_iqcomp === 1'b1) got = n;
    end
    checks++;
    if (got != 128) begin
      failures++;
      $display("FAIL spike_restart got=%0d want=128", got);
    end
  endtask

  task automatic test_inclusive();
    int got = 0;
    do_reset();
    bus.thresh = 8'd7; bus.op_mode = 2'b01; bus.enable = 1'b1;
    @(negedge clk);
    for (int n = 1; n <= 200 && got == 0; n++) begin
      bus.Wr = (n % 2) ? 13'sd17 : 13'sd10;
      bus.Wj = (n % 3 == 0) ? 13'sd2 : -13'sd5;
      @(negedge clk);
      if (bus.freeze_iqcomp === 1'b1) got = n;
    end
    checks++;
    if (got != 64 || bus.settled !== 1'b1) begin
      failures++;
      $display("FAIL thresh_inclusive got lat=%0d set=%0b want 64 1", got, bus.settled);
    end
  endtask

  task automatic test_extremes();
    int got = 0;
    do_reset();
    bus.thresh = 8'd255; bus.Wj = '0; bus.op_mode = 2'b01; bus.enable = 1'b1;
    @(negedge clk);
    for (int n = 1; n <= 200; n++) begin
      bus.Wr = (n % 2) ? 13'sd4095 : -13'sd4096;
      @(negedge clk);
      if (bus.freeze_iqcomp === 1'b1 && got == 0) got = n;
    end
    checks++;
    if (got != 0 || bus.state !== 2'b01) begin
      failures++;
      $display("FAIL extreme_span got frz_at=%0d st=%0d want 0 1", got, bus.state);
    end
  endtask

  task automatic test_abort_enable();
    int got = 0;
    do_reset();
    bus.Wr = 13'sd5; bus.Wj = 13'sd6; bus.thresh = 8'd0;
    bus.op_mode = 2'b01; bus.enable = 1'b1;
    repeat (21) @(negedge clk);
    bus.enable = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.state !== 2'b00 || bus.freeze_iqcomp !== 1'b0) begin
      failures++;
      $display("FAIL abort_enable got st=%0d frz=%0b want 0 0", bus.state, bus.freeze_iqcomp);
    end
    bus.enable = 1'b1;
    @(negedge clk);
    for (int n = 1; n <= 200 && got == 0; n++) begin
      @(negedge clk);
      if (bus.freeze_iqcomp === 1'b1) got = n;
    end
    checks++;
    if (got != 64) begin
      failures++;
      $display("FAIL abort_rerun got=%0d want=64", got);
    end
  endtask

  task automatic test_abort_mode();
    int got = 0;
    do_reset();
    bus.Wr = -13'sd1234; bus.Wj = 13'sd777; bus.thresh = 8'd0;
    bus.op_mode = 2'b01; bus.enable = 1'b1;
    @(negedge clk);
    for (int n = 1; n <= 200 && got == 0; n++) begin
      @(negedge clk);
      if (bus.freeze_iqcomp === 1'b1) got = n;
    end
    bus.op_mode = 2'b10; bus.Wr = 13'sd1; bus.Wj = 13'sd2;
    @(negedge clk);
    checks++;
    if (got != 64 || bus.freeze_iqcomp !== 1'b0 || bus.state !== 2'b00 || bus.settled !== 1'b0) begin
      failures++;
      $display("FAIL abort_mode got lat=%0d frz=%0b st=%0d set=%0b want 64 0 0 0",
               got, bus.freeze_iqcomp, bus.state, bus.settled);
    end
    checks++;
    if ($signed(bus.Wr_hold) !== -1234 || $signed(bus.Wj_hold) !== 777) begin
      failures++;
      $display("FAIL hold_retained got hr=%0d hj=%0d want -1234 777",
               $signed(bus.Wr_hold), $signed(bus.Wj_hold));
    end
  endtask

  task automatic test_reset_mid();
    int got = 0;
    bus.enable = 1'b0;
    @(negedge clk);
    bus.Wr = 13'sd40; bus.Wj = 13'sd41; bus.thresh = 8'd0;
    bus.op_mode = 2'b01; bus.enable = 1'b1;
    repeat (41) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.state, bus.freeze_iqcomp, bus.settled, bus.timeout, bus.Wr_hold, bus.Wj_hold} !== '0) begin
      failures++;
      $display("FAIL reset_mid got st=%0d frz=%0b hr=%0d hj=%0d want all 0",
               bus.state, bus.freeze_iqcomp, bus.Wr_hold, bus.Wj_hold);
    end
    rstn = 1'b1;
    @(negedge clk);
    for (int n = 1; n <= 200 && got == 0; n++) begin
      @(negedge clk);
      if (bus.freeze_iqcomp === 1'b1) got = n;
    end
    checks++;
    if (got != 64) begin
      failures++;
      $display("FAIL reset_rerun got=%0d want=64", got);
    end
  endtask

  task automatic test_random();
    int seg = 0, base_r = 0, base_j = 0, nz_r = 0, nz_j = 0;
    logic en_seg = 1'b1;
    do_reset();
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      checks++;
      if ({bus.state, bus.freeze_iqcomp, bus.settled, bus.timeout} !==
          {m_st, (m_st == 2'd2 || m_st == 2'd3), (m_st == 2'd2), (m_st == 2'd3)} ||
          $signed(bus.Wr_hold) !== m_hr || $signed(bus.Wj_hold) !== m_hj) begin
        failures++;
        $display("FAIL random c=%0d got st=%0d frz=%0b hr=%0d hj=%0d want st=%0d hr=%0d hj=%0d",
                 c, bus.state, bus.freeze_iqcomp, $signed(bus.Wr_hold), $signed(bus.Wj_hold),
                 m_st, m_hr, m_hj);
      end
      if (seg == 0) begin
        seg    = $urandom_range(40, 1500);
        base_r = int'($urandom_range(0, 8000)) - 4000;
        base_j = int'($urandom_range(0, 8000)) - 4000;
        nz_r   = $urandom_range(0, 12);
        nz_j   = $urandom_range(0, 12);
        bus.thresh  = 8'($urandom_range(0, 10));
        bus.op_mode = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b01;
        en_seg = ($urandom_range(0, 9) != 0);
      end
      seg--;
      bus.enable = en_seg && ($urandom_range(0, 499) != 0);
      rstn       = ($urandom_range(0, 1999) != 0);
      bus.Wr = W'(base_r + int'($urandom_range(0, nz_r)));
      bus.Wj = W'(base_j + int'($urandom_range(0, nz_j)));
    end
    rstn = 1'b1;
  endtask

  initial begin
    bus.enable = 1'b0; bus.op_mode = 2'b00; bus.Wr = '0; bus.Wj = '0; bus.thresh = '0;
    test_reset();
    test_settle_const();
    test_timeout_osc();
    test_spike();
    test_inclusive();
    test_extremes();
    test_abort_enable();
    test_abort_mode();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/iq_settle_detect.md
# iq_settle_detect

Convergence monitor for the IQ compensation loop, sitting directly beside the compensator and closing its control loop. It consumes the compensator's internally adapted weights Wr/Wj every clock and measures their peak-to-peak span over fixed windows. Once the weights stay inside a programmable threshold for a set number of consecutive windows, it asserts the compensator's freeze input and latches the settled weights for MCU readback. If convergence takes too long, a timeout freezes the loop instead.

## Interface
- W_WIDTH, 13: weight width (signed).
- WIN_LOG2, 4: window length = 2^WIN_LOG2 samples.
- HOLD_WINDOWS, 4: consecutive stable windows required to settle (≥1).
- TIMEOUT_WINDOWS, 64: windows evaluated before timeout (> HOLD_WINDOWS).
- clk  in  1  clock.
- RESETn  in  1  reset, synchronous, active-low.
- enable  in  1  start/hold request from start-signal FSM; low forces IDLE.
- op_mode  in  2  compensator mode; monitoring only in INT_W (2'b01).
- Wr, Wj  in  W_WIDTH  signed weights from compensator, one new sample per clock.
- thresh  in  8  unsigned max allowed span (inclusive) for both weights.
- freeze_iqcomp  out  1  to compensator; high in SETTLED or TIMEOUT.
- settled  out  1  high only in SETTLED.
- timeout  out  1  high only in TIMEOUT.
- state  out  2  debug state encoding.
- Wr_hold, Wj_hold  out  W_WIDTH  weights latched at settle.

## Operation
- States: IDLE=00, TRACK=01, SETTLED=10, TIMEOUT=11.
- IDLE: counters cleared, freeze_iqcomp/settled/timeout = 0. Go to TRACK when enable=1 and op_mode=INT_W.
- TRACK: sample index k counts 0..2^WIN_LOG2-1. At k=0, min/max for each weight load the current sample. Otherwise they update with signed compare.
- At the last sample of a window, compute span = max − min using the final sample as well. Span width is W_WIDTH+1, unsigned, with no wrap.
- Window stable if span_r ≤ thresh AND span_j ≤ thresh.
- Stable window: stable_cnt += 1. Unstable window: stable_cnt = 0. win_cnt += 1 every window.
- stable_cnt reaching HOLD_WINDOWS → SETTLED. Latch Wr_hold/Wj_hold from the final sample of that window.
- Else win_cnt reaching TIMEOUT_WINDOWS → TIMEOUT. Wr_hold/Wj_hold latch the final sample.
- Both in the same window end: SETTLED wins.
- SETTLED/TIMEOUT: hold until enable=0 or op_mode≠INT_W, then → IDLE. Wr_hold/Wj_hold keep their values in IDLE and update only at the next latch.
- In any state, enable=0 or op_mode≠INT_W → IDLE on the next edge, aborting the window.

## Timing
- Reset: state=IDLE, all outputs 0, Wr_hold=Wj_hold=0, all counters 0.
- Enable/op_mode are sampled at edge t, and state=TRACK from t+1. The sample present during the first TRACK cycle is k=0.
- Window evaluation is registered. The state change and freeze_iqcomp appear on the edge that consumes the last window sample.
- Minimum settle: freeze_iqcomp high exactly HOLD_WINDOWS·2^WIN_LOG2 cycles after entering TRACK (64 with defaults).
- Timeout: TIMEOUT_WINDOWS·2^WIN_LOG2 cycles after entering TRACK (1024 with defaults).
- Exit: enable drop at edge t → freeze_iqcomp low from t+1.
- Since the compensator holds W while frozen, the inputs are ignored outside TRACK.
- RESETn low mid-window clears everything on that edge; no partial window survives.

## Structure
- Shared package iq_comp_pkg holds:
  - op_mode constants BYPASS=2'b00, INT_W=2'b01, EXT_W=2'b10;
  - state encodings IDLE/TRACK/SETTLED/TIMEOUT.
- Sub-module iq_span_tracker (W_WIDTH, load, sample → min, max, span) is instantiated twice, once for Wr and once for Wj.
- Top level contains the FSM, the sample/window/stable counters (sized via $clog2), and the hold registers.

## Test plan
- Settle on constant weights:
  - Stimulus: defaults, Wr=100, Wj=−37 constant, thresh=0, enable at cycle 0.
  - Response: freeze_iqcomp=settled=1 exactly 64 cycles after TRACK entry; Wr_hold=100, Wj_hold=−37.
- Timeout on oscillating weight:
  - Stimulus: Wr alternating 0/3, Wj=0, thresh=2.
  - Response: no settle; timeout=1, freeze_iqcomp=1, settled=0 at 1024 cycles; Wr_hold equals the last sample.
- Unstable window resets the stable count:
  - Stimulus: constant weights, thresh=5, one Wj spike of +6 in window 3.
  - Response: settle at end of window 7 (128 cycles).
- Threshold is inclusive, and signed extremes do not wrap:
  - Stimulus A: span exactly equal to thresh. Response: settles.
  - Stimulus B: Wr alternating −4096/+4095, thresh=255. Response: span=8191, unstable.
- Abort paths:
  - enable dropped mid-TRACK → IDLE next cycle.
  - op_mode=EXT_W while SETTLED → freeze_iqcomp=0 next cycle.
  - RESETn low during window 2 → all outputs 0 next edge; the next run needs the full 64 cycles to settle.
